mult_acc_128: RTL and testbench

- Stage directly downstream of the 64x64 pipelined multiplier (2-cycle latency, 128-bit unsigned product).
- Consumes the product stream and accumulates products into groups delimited by a LAST marker.
- Presents each completed group sum, with its product count, on a valid/ready output holding register.
- The multiplier has no stall, so this block never backpressures its input. Overrun is flagged, not stalled.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_acc_out_reg.sv | 102 ++++++++++
 rtl/mult_acc_128.sv | 166 ++++++++++++++++
 tb/tb_mult_acc_128.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, defaults and state types for the
// 64x64 multiplier and its downstream group accumulator.
package mult_pkg;

  localparam int PROD_W    = 128;
  localparam int OP_W      = 64;
  localparam int MULT_LAT  = 2;
  localparam int ACC_W_DEF = 136;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    IDLE,
    ACCUM
  } grp_state_t;

  typedef enum logic {
    EMPTY,
    FULL
  } out_state_t;

endpackage

// File: rtl/mult_acc_out_reg.sv
// mult_acc_out_reg: valid/ready holding register for group results.
// Drops and flags a result that arrives while full and not drained.
module mult_acc_out_reg
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_CLK,
  input  logic             i_RST_n,
  input  logic             i_LOAD,
  input  logic [ACC_W-1:0] i_SUM,
  input  logic [CNT_W-1:0] i_CNT,
  input  logic             i_SAT,
  input  logic             i_CLR,
  input  logic             i_READY,
  output logic             o_VALID,
  output logic [ACC_W-1:0] o_SUM,
  output logic [CNT_W-1:0] o_CNT,
  output logic             o_SAT,
  output logic             o_DROP
);

  out_state_t       st_q;
  out_state_t       st_d;
  logic             load;
  logic             drop_set;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             drop_q;

  // Holding-register state, load strobe and drop detection.
  always_comb begin
    st_d     = st_q;
    load     = 1'b0;
    drop_set = 1'b0;
    unique case (st_q)
      EMPTY: begin
        if (i_LOAD) begin
          load = 1'b1;
          st_d = FULL;
        end
      end
      FULL: begin
        if (i_READY) begin
          if (i_LOAD) begin
            load = 1'b1;
          end else begin
            st_d = EMPTY;
          end
        end else if (i_LOAD) begin
          drop_set = 1'b1;
        end
      end
      default: st_d = EMPTY;
    endcase
  end

  // State, payload and sticky drop flag.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      st_q   <= EMPTY;
      sum_q  <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      drop_q <= (drop_q & ~i_CLR) | drop_set;
      if (load) begin
        sum_q <= i_SUM;
        cnt_q <= i_CNT;
      end
    end
  end

`ifdef MULT_ACC_SAT_EN
  logic sat_q;

  // Saturation bit rides with the held result.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      sat_q <= 1'b0;
    end else if (load) begin
      sat_q <= i_SAT;
    end else if (i_CLR) begin
      sat_q <= 1'b0;
    end
  end

  assign o_SAT = sat_q;
`else
  logic unused_sat;
  assign unused_sat = i_SAT;
  assign o_SAT      = 1'b0;
`endif

  assign o_VALID = (st_q == FULL);
  assign o_SUM   = sum_q;
  assign o_CNT   = cnt_q;
  assign o_DROP  = drop_q;

endmodule

// File: rtl/mult_acc_128.sv
// mult_acc_128: accumulates multiplier products into LAST-delimited
// groups; optional MULT_ACC_SAT_EN saturates the group sum.
module mult_acc_128
  import mult_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              i_CLK,
  input  logic              i_RST_n,
  input  logic              i_PROD_VALID,
  input  logic [PROD_W-1:0] i_PROD,
  input  logic              i_LAST,
  input  logic              i_CLR,
  output logic              o_VALID,
  input  logic              i_READY,
  output logic [ACC_W-1:0]  o_SUM,
  output logic [CNT_W-1:0]  o_CNT,
  output logic              o_DROP,
  output logic              o_SAT
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  grp_state_t       grp_q;
  grp_state_t       grp_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             fresh;
  logic [ACC_W-1:0] base_acc;
  logic [CNT_W-1:0] base_cnt;
  logic [ACC_W-1:0] prod_x;
  logic [ACC_W-1:0] sum_n;
  logic [CNT_W-1:0] cnt_n;
  logic             sat_n;
  logic             emit;

  logic             em_v_q;
  logic [ACC_W-1:0] em_sum_q;
  logic [CNT_W-1:0] em_cnt_q;
  logic             em_sat_q;

  // A clear or an idle group starts the sum from zero.
  assign fresh    = i_CLR | (grp_q == IDLE);
  assign base_acc = fresh ? '0 : acc_q;
  assign base_cnt = fresh ? '0 : cnt_q;
  assign prod_x   = ACC_W'(i_PROD);
  assign cnt_n    = (base_cnt == CNT_MAX) ? base_cnt
                                          : base_cnt + CNT_W'(1);

`ifdef MULT_ACC_SAT_EN
  logic             sat_q;
  logic             sat_d;
  logic             base_sat;
  logic [ACC_W:0]   wide;

  assign base_sat = fresh ? 1'b0 : sat_q;
  assign wide     = {1'b0, base_acc} + {1'b0, prod_x};
  assign sat_n    = base_sat | wide[ACC_W];
  assign sum_n    = sat_n ? '1 : wide[ACC_W-1:0];

  // Per-group saturation bit follows the group lifetime.
  always_comb begin
    sat_d = sat_q;
    unique case (1'b1)
      i_PROD_VALID &  i_LAST: sat_d = 1'b0;
      i_PROD_VALID & ~i_LAST: sat_d = sat_n;
      ~i_PROD_VALID & i_CLR:  sat_d = 1'b0;
      default:                sat_d = sat_q;
    endcase
  end

  // Saturation state register.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
    end
  end
`else
  assign sat_n = 1'b0;
  assign sum_n = base_acc + prod_x;
`endif

  // Group FSM: accumulate, emit on LAST, discard on clear.
  always_comb begin
    grp_d = grp_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    emit  = 1'b0;
    unique case (1'b1)
      i_PROD_VALID & i_LAST: begin
        emit  = 1'b1;
        grp_d = IDLE;
        acc_d = '0;
        cnt_d = '0;
      end
      i_PROD_VALID & ~i_LAST: begin
        grp_d = ACCUM;
        acc_d = sum_n;
        cnt_d = cnt_n;
      end
      ~i_PROD_VALID & i_CLR: begin
        grp_d = IDLE;
        acc_d = '0;
        cnt_d = '0;
      end
      default: begin
        grp_d = grp_q;
      end
    endcase
  end

  // Group state, accumulator and counter.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      grp_q <= IDLE;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      grp_q <= grp_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // Emit stage registers the finished group ahead of the output.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      em_v_q   <= 1'b0;
      em_sum_q <= '0;
      em_cnt_q <= '0;
      em_sat_q <= 1'b0;
    end else begin
      em_v_q <= emit;
      if (emit) begin
        em_sum_q <= sum_n;
        em_cnt_q <= cnt_n;
        em_sat_q <= sat_n;
      end
    end
  end

  mult_acc_out_reg #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_out (
    .i_CLK   (i_CLK),
    .i_RST_n (i_RST_n),
    .i_LOAD  (em_v_q),
    .i_SUM   (em_sum_q),
    .i_CNT   (em_cnt_q),
    .i_SAT   (em_sat_q),
    .i_CLR   (i_CLR),
    .i_READY (i_READY),
    .o_VALID (o_VALID),
    .o_SUM   (o_SUM),
    .o_CNT   (o_CNT),
    .o_SAT   (o_SAT),
    .o_DROP  (o_DROP)
  );

endmodule

// File: tb/tb_mult_acc_128.sv
// tb_mult_acc_128: vector table plus scoreboard for mult_acc_128,
// with a narrow instance for overflow and count saturation.
module tb_mult_acc_128;
  import mult_pkg::*;

  localparam int AW  = 136;
  localparam int CW  = 8;
  localparam int SAW = 128;
  localparam int SCW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           pv, last, clr, ready;
  logic [127:0]   prod;
  logic           vld, drop, sat;
  logic [AW-1:0]  sum;
  logic [CW-1:0]  cnt;
  logic           s_vld, s_drop, s_sat;
  logic [SAW-1:0] s_sum;
  logic [SCW-1:0] s_cnt;

  mult_acc_128 u_dut (
    .i_CLK(clk), .i_RST_n(rst_n), .i_PROD_VALID(pv),
    .i_PROD(prod), .i_LAST(last), .i_CLR(clr),
    .o_VALID(vld), .i_READY(ready), .o_SUM(sum),
    .o_CNT(cnt), .o_DROP(drop), .o_SAT(sat)
  );

  mult_acc_128 #(.ACC_W(SAW), .CNT_W(SCW)) u_small (
    .i_CLK(clk), .i_RST_n(rst_n), .i_PROD_VALID(pv),
    .i_PROD(prod), .i_LAST(last), .i_CLR(clr),
    .o_VALID(s_vld), .i_READY(ready), .o_SUM(s_sum),
    .o_CNT(s_cnt), .o_DROP(s_drop), .o_SAT(s_sat)
  );

  typedef struct {
    logic [AW-1:0] sum;
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    logic         v;
    logic [127:0] p;
    logic         l;
    logic         c;
    logic         ev;
  } vec_t;

  exp_t          sb[$];
  vec_t          tbl[22];
  int            n_chk = 0;
  int            n_fail = 0;
  bit            sb_en = 1'b1;
  logic [AW-1:0] m_acc = '0;
  logic [CW-1:0] m_cnt = '0;
  logic [127:0]  pmax = '1;

  task automatic chk(input string nm, input logic [AW-1:0] act,
                     input logic [AW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [127:0] p,
                     input logic l, input logic c, input logic r);
    exp_t e;
    pv = v; prod = p; last = l; clr = c; ready = r;
    if (vld && ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_extra: got sum %0h want none", sum);
      end else begin
        e = sb.pop_front();
        chk("sb_sum", sum, e.sum);
        chk("sb_cnt", AW'(cnt), AW'(e.cnt));
        chk("sb_sat", AW'(sat), '0);
      end
    end
    if (c) begin
      m_acc = '0;
      m_cnt = '0;
    end
    if (v) begin
      m_acc = m_acc + AW'(p);
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (l) begin
        if (sb_en) sb.push_back('{m_acc, m_cnt});
        m_acc = '0;
        m_cnt = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [SAW-1:0] exp_ov;
    logic           exp_ovs;
`ifdef MULT_ACC_SAT_EN
    exp_ov  = '1;
    exp_ovs = 1'b1;
`else
    exp_ov  = 128'd1;
    exp_ovs = 1'b0;
`endif
    tbl[0]  = '{1'b1, 128'd3,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 128'd5,  1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 128'd7,  1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 128'd0,  1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 128'd0,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, pmax,    1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 128'd1,  1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 128'd2,  1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 128'd3,  1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 128'd0,  1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 128'd0,  1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 128'd4,  1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 128'd4,  1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 128'd9,  1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 128'd0,  1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 128'd0,  1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 128'd0,  1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 128'd6,  1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 128'd0,  1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b1, 128'd1,  1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 128'd0,  1'b0, 1'b0, 1'b1};
    tbl[21] = '{1'b0, 128'd0,  1'b0, 1'b0, 1'b0};

    pv = 0; prod = '0; last = 0; clr = 0; ready = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", AW'(vld), '0);
    chk("rst_sum", sum, '0);
    chk("rst_cnt", AW'(cnt), '0);
    chk("rst_drop", AW'(drop), '0);
    chk("rst_sat", AW'(sat), '0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].v, tbl[i].p, tbl[i].l, tbl[i].c, 1'b1);
      chk($sformatf("vec%0d_valid", i), AW'(vld), AW'(tbl[i].ev));
    end
    chk("tbl_drained", AW'(sb.size()), '0);

    cyc(1'b1, 128'd10, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b0);
    chk("bp_a_valid", AW'(vld), AW'(1));
    sb_en = 1'b0;
    cyc(1'b1, 128'd20, 1'b1, 1'b0, 1'b0);
    sb_en = 1'b1;
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b0);
    chk("bp_hold_valid", AW'(vld), AW'(1));
    chk("bp_hold_sum", sum, AW'(10));
    chk("bp_drop_set", AW'(drop), AW'(1));
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b1);
    chk("bp_consumed", AW'(vld), '0);
    chk("bp_drop_sticky", AW'(drop), AW'(1));
    cyc(1'b0, 128'd0, 1'b0, 1'b1, 1'b1);
    chk("bp_drop_clr", AW'(drop), '0);

    sb_en = 1'b0;
    cyc(1'b1, 128'd4, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 128'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 128'd6, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 128'd8, 1'b0, 1'b0, 1'b0);
    chk("ar_pre_valid", AW'(vld), AW'(1));
    chk("ar_pre_drop", AW'(drop), AW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", AW'(vld), '0);
    chk("ar_sum", sum, '0);
    chk("ar_cnt", AW'(cnt), '0);
    chk("ar_drop", AW'(drop), '0);
    m_acc = '0;
    m_cnt = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb_en = 1'b1;
    cyc(1'b1, 128'd1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b1);
    chk("ar_post_cnt", AW'(cnt), AW'(1));
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b1);

    cyc(1'b1, pmax, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 128'd2, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b1);
    chk("ov_valid", AW'(s_vld), AW'(1));
    chk("ov_sum", AW'(s_sum), AW'(exp_ov));
    chk("ov_sat", AW'(s_sat), AW'(exp_ovs));
    cyc(1'b1, 128'd1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b1);
    chk("ov_next_sum", AW'(s_sum), AW'(1));
    chk("ov_next_sat", AW'(s_sat), '0);
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) cyc(1'b1, 128'd1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 128'd1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b1);
    chk("cs_cnt", AW'(s_cnt), AW'(3));
    chk("cs_sum", AW'(s_sum), AW'(5));
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 128'd0, 1'b0, 1'b0, 1'b1);
    chk("sb_final_empty", AW'(sb.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
